// File: rtl/l1_cache_nway.sv
// Write-back, write-allocate N-way L1 cache with 16-bit CPU words and 128-bit memory lines.
// Hits complete combinationally in IDLE; misses go through optional WRITEBACK then FILL.
module l1_cache_nway #(
    parameter int WAYS       = 2,
    parameter int INDEX_BITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = 12 - INDEX_BITS;
    localparam int WAY_BITS = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
    state_t state_reg, state_next;

    logic [127:0]          data_arr [WAYS][SETS];
    logic [TAG_BITS-1:0]   tag_arr  [WAYS][SETS];
    logic [SETS-1:0][WAYS-1:0] valid_reg, dirty_reg;
    logic [SETS-1:0][WAYS-2:0] plru_reg;
    logic [WAY_BITS-1:0]   victim_reg;
    logic [11:0]           line_reg;

    logic [2:0]            offset;
    logic [INDEX_BITS-1:0] index, line_index;
    logic [TAG_BITS-1:0]   addr_tag, line_tag;
    logic                  request, hit, addr_unused;
    logic [WAYS-1:0]       way_hit;
    logic [WAY_BITS-1:0]   hit_way, victim_sel, plru_victim;
    logic [WAYS-2:0]       plru_cur, plru_upd;
    logic [127:0]          hit_line, merged_line;
    logic                  miss_start, fill_done, hit_write;

    assign offset      = mem_address[3:1];
    assign index       = mem_address[3+INDEX_BITS:4];
    assign addr_tag    = mem_address[15:4+INDEX_BITS];
    assign addr_unused = mem_address[0];
    assign request     = mem_read | mem_write;
    // Miss line address is latched so a request dropped mid-miss cannot disturb the transfer.
    assign line_index  = line_reg[INDEX_BITS-1:0];
    assign line_tag    = line_reg[11:INDEX_BITS];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_hit
            assign way_hit[gi] = valid_reg[index][gi] && (tag_arr[gi][index] == addr_tag);
        end
    endgenerate

    assign hit = |way_hit;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_way = WAY_BITS'(w);
        end
    end

    always_comb begin
        victim_sel = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[index][w]) victim_sel = WAY_BITS'(w);
        end
    end

    assign plru_cur = plru_reg[index];

    generate
        if (WAYS == 4) begin : g_plru4
            // b0 picks the pair, b1/b2 pick within pair 0/1; bits point at the LRU side.
            assign plru_victim = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
            always_comb begin
                plru_upd = plru_cur;
                if (!hit_way[1]) begin
                    plru_upd[0] = 1'b1;
                    plru_upd[1] = ~hit_way[0];
                end else begin
                    plru_upd[0] = 1'b0;
                    plru_upd[2] = ~hit_way[0];
                end
            end
        end else begin : g_plru2
            assign plru_victim = plru_cur[0];
            assign plru_upd    = ~hit_way;
        end
    endgenerate

    assign hit_line  = data_arr[hit_way][index];
    assign mem_rdata = hit_line[{offset, 4'h0} +: 16];

    always_comb begin
        merged_line = hit_line;
        if (mem_byte_enable[0]) merged_line[{offset, 4'h0} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged_line[{offset, 4'h8} +: 8] = mem_wdata[15:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (request && !hit) begin
                    state_next = (valid_reg[index][victim_sel] && dirty_reg[index][victim_sel])
                                 ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: if (pmem_resp) state_next = FILL;
            FILL:      if (pmem_resp) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        miss_start   = 1'b0;
        fill_done    = 1'b0;
        pmem_address = {line_reg, 4'b0000};
        case (state_reg)
            IDLE: begin
                mem_resp   = request && hit;
                miss_start = request && !hit;
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[victim_reg][line_index], line_index, 4'b0000};
            end
            FILL: begin
                pmem_read = 1'b1;
                fill_done = pmem_resp;
            end
            default: ;
        endcase
    end

    assign hit_write  = mem_resp && mem_write;
    assign pmem_wdata = data_arr[victim_reg][line_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= '0;
            dirty_reg  <= '0;
            plru_reg   <= '0;
            victim_reg <= '0;
            line_reg   <= '0;
        end else begin
            if (mem_resp) plru_reg[index] <= plru_upd;
            if (hit_write) dirty_reg[index][hit_way] <= 1'b1;
            if (miss_start) begin
                victim_reg <= victim_sel;
                line_reg   <= mem_address[15:4];
            end
            if (fill_done) begin
                valid_reg[line_index][victim_reg] <= 1'b1;
                dirty_reg[line_index][victim_reg] <= 1'b0;
            end
        end
    end

    // Line and tag storage carry no reset; their contents are qualified by valid_reg.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_arr[victim_reg][line_index] <= pmem_rdata;
            tag_arr[victim_reg][line_index]  <= line_tag;
        end else if (hit_write) begin
            data_arr[hit_way][index] <= merged_line;
        end
    end
endmodule

// File: tb/tb_l1_cache_nway.sv
// Directed bench for l1_cache_nway: a 2-way (u=0) and a 4-way (u=1) instance share clock and reset.
// Memory word w of line L reads as {L[15:4], 1'b0, w}.
module tb_l1_cache_nway;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_read [2];
    logic         mem_write [2];
    logic [15:0]  mem_address [2];
    logic [15:0]  mem_wdata [2];
    logic [1:0]   mem_byte_enable [2];
    logic [15:0]  mem_rdata [2];
    logic         mem_resp [2];
    logic         pmem_read [2];
    logic         pmem_write [2];
    logic [15:0]  pmem_address [2];
    logic [127:0] pmem_wdata [2];
    logic [127:0] pmem_rdata [2];
    logic         pmem_resp [2];

    int           applied = 0;
    int           miscompares = 0;
    int           cnt [2];
    int           fills [2];
    int           wbs [2];
    logic [15:0]  last_fill [2];
    logic [15:0]  last_wb [2];
    logic [127:0] first_wb_data [2];
    logic         hold [2];
    logic         inject [2];

    l1_cache_nway #(.WAYS(2), .INDEX_BITS(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]),
        .mem_byte_enable(mem_byte_enable[0]),
        .mem_rdata(mem_rdata[0]), .mem_resp(mem_resp[0]),
        .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]),
        .pmem_address(pmem_address[0]), .pmem_wdata(pmem_wdata[0]),
        .pmem_rdata(pmem_rdata[0]), .pmem_resp(pmem_resp[0])
    );

    l1_cache_nway #(.WAYS(4), .INDEX_BITS(3)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]),
        .mem_byte_enable(mem_byte_enable[1]),
        .mem_rdata(mem_rdata[1]), .mem_resp(mem_resp[1]),
        .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]),
        .pmem_address(pmem_address[1]), .pmem_wdata(pmem_wdata[1]),
        .pmem_rdata(pmem_rdata[1]), .pmem_resp(pmem_resp[1])
    );

    initial forever #5 clk = ~clk;

    function automatic logic [127:0] line_of(input logic [15:0] a);
        logic [127:0] l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = {a[15:4], 1'b0, 3'(w)};
        return l;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s [%0d]: got %h, want %h", name, idx, act, exp);
        end
    endtask

    // Physical memory: answers each transfer after LAT cycles unless held, then mirrors inject.
    initial begin
        for (int u = 0; u < 2; u++) begin
            cnt[u] = 0; fills[u] = 0; wbs[u] = 0;
            last_fill[u] = '0; last_wb[u] = '0; first_wb_data[u] = '0;
            pmem_resp[u] = 1'b0; pmem_rdata[u] = '0;
        end
        forever begin
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                if (pmem_read[u] === 1'b1 && pmem_write[u] === 1'b1) begin
                    miscompares++;
                    $display("FAIL pmem_both [%0d]: got read=1 write=1, want exclusive", u);
                end
                if (hold[u]) begin
                    pmem_resp[u] = inject[u];
                    cnt[u] = 0;
                end else begin
                    pmem_resp[u] = 1'b0;
                    if (pmem_read[u] || pmem_write[u]) begin
                        cnt[u]++;
                        if (cnt[u] == LAT) begin
                            cnt[u] = 0;
                            pmem_resp[u] = 1'b1;
                            if (pmem_write[u]) begin
                                if (wbs[u] == 0) first_wb_data[u] = pmem_wdata[u];
                                wbs[u]++;
                                last_wb[u] = pmem_address[u];
                            end else begin
                                fills[u]++;
                                last_fill[u] = pmem_address[u];
                                pmem_rdata[u] = line_of(pmem_address[u]);
                            end
                        end
                    end else begin
                        cnt[u] = 0;
                    end
                end
            end
        end
    end

    // Starts just after a rising edge; returns just after the edge that retires the request.
    task automatic access(input int u, input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic [1:0] be,
                          output int lat, output logic [15:0] rdata);
        mem_read[u] = rd; mem_write[u] = wr; mem_address[u] = a;
        mem_wdata[u] = wd; mem_byte_enable[u] = be;
        lat = 0;
        rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_resp[u]) break;
            lat++;
            if (lat > 40) begin
                applied++; miscompares++;
                $display("FAIL timeout [%0d]: got no mem_resp for %h, want one within 40 cycles", u, a);
                break;
            end
        end
        rdata = mem_rdata[u];
        @(posedge clk); #1;
        mem_read[u] = 1'b0; mem_write[u] = 1'b0;
    endtask

    typedef struct {
        int          u;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [1:0]  be;
        int          lat;
        logic [15:0] rdata;
        logic        chk_rd;
        int          wbs;
        logic [15:0] wba;
        logic [15:0] fa;
    } vec_t;

    vec_t vecs [23];

    initial begin
        int          lat;
        int          wb0;
        int          pulses;
        logic        saw_fill;
        logic [15:0] rdata;

        vecs[0]  = '{0, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 3, 16'h1232, 1'b1, 0, 16'h0000, 16'h1230};
        vecs[1]  = '{0, 1'b1, 1'b0, 16'h1236, 16'h0000, 2'b00, 0, 16'h1233, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[2]  = '{0, 1'b0, 1'b1, 16'h1234, 16'h5555, 2'b11, 0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000};
        vecs[3]  = '{0, 1'b0, 1'b1, 16'h1234, 16'hABCD, 2'b01, 0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000};
        vecs[4]  = '{0, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 0, 16'h55CD, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[5]  = '{0, 1'b0, 1'b1, 16'h1236, 16'hFFFF, 2'b00, 0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000};
        vecs[6]  = '{0, 1'b1, 1'b0, 16'h1236, 16'h0000, 2'b00, 0, 16'h1233, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[7]  = '{0, 1'b1, 1'b1, 16'h1238, 16'h7777, 2'b11, 0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000};
        vecs[8]  = '{0, 1'b1, 1'b0, 16'h1238, 16'h0000, 2'b00, 0, 16'h7777, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[9]  = '{0, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 3, 16'h0001, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[10] = '{0, 1'b0, 1'b1, 16'h0084, 16'hBEEF, 2'b11, 3, 16'h0000, 1'b0, 0, 16'h0000, 16'h0080};
        vecs[11] = '{0, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[12] = '{0, 1'b1, 1'b0, 16'h010E, 16'h0000, 2'b00, 5, 16'h0107, 1'b1, 1, 16'h0080, 16'h0100};
        vecs[13] = '{0, 1'b1, 1'b0, 16'h0180, 16'h0000, 2'b00, 3, 16'h0180, 1'b1, 0, 16'h0000, 16'h0180};
        vecs[14] = '{1, 1'b0, 1'b1, 16'h0000, 16'h1111, 2'b11, 3, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000};
        vecs[15] = '{1, 1'b0, 1'b1, 16'h0080, 16'h2222, 2'b11, 3, 16'h0000, 1'b0, 0, 16'h0000, 16'h0080};
        vecs[16] = '{1, 1'b0, 1'b1, 16'h0100, 16'h3333, 2'b11, 3, 16'h0000, 1'b0, 0, 16'h0000, 16'h0100};
        vecs[17] = '{1, 1'b0, 1'b1, 16'h0180, 16'h4444, 2'b11, 3, 16'h0000, 1'b0, 0, 16'h0000, 16'h0180};
        vecs[18] = '{1, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b00, 5, 16'h0200, 1'b1, 1, 16'h0000, 16'h0200};
        vecs[19] = '{1, 1'b1, 1'b0, 16'h0202, 16'h0000, 2'b00, 0, 16'h0201, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[20] = '{1, 1'b1, 1'b0, 16'h0280, 16'h0000, 2'b00, 5, 16'h0280, 1'b1, 1, 16'h0100, 16'h0280};
        vecs[21] = '{1, 1'b1, 1'b0, 16'h0080, 16'h0000, 2'b00, 0, 16'h2222, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[22] = '{1, 1'b1, 1'b0, 16'h0180, 16'h0000, 2'b00, 0, 16'h4444, 1'b1, 0, 16'h0000, 16'h0000};

        for (int u = 0; u < 2; u++) begin
            mem_read[u] = 1'b0; mem_write[u] = 1'b0; mem_address[u] = '0;
            mem_wdata[u] = '0; mem_byte_enable[u] = '0;
            hold[u] = 1'b0; inject[u] = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset_mem_resp", u, 32'(mem_resp[u]), 32'd0);
            check("reset_pmem_read", u, 32'(pmem_read[u]), 32'd0);
            check("reset_pmem_write", u, 32'(pmem_write[u]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 23; i++) begin
            wb0 = wbs[vecs[i].u];
            access(vecs[i].u, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be, lat, rdata);
            $display("vec %0d u%0d addr=%h rd=%0d wr=%0d lat=%0d rdata=%h", i, vecs[i].u,
                     vecs[i].addr, vecs[i].rd, vecs[i].wr, lat, rdata);
            check("latency", i, 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].chk_rd) check("rdata", i, 32'(rdata), 32'(vecs[i].rdata));
            check("writebacks", i, 32'(wbs[vecs[i].u] - wb0), 32'(vecs[i].wbs));
            if (vecs[i].wbs > 0) check("wb_addr", i, 32'(last_wb[vecs[i].u]), 32'(vecs[i].wba));
            if (vecs[i].lat > 0) check("fill_addr", i, 32'(last_fill[vecs[i].u]), 32'(vecs[i].fa));
        end

        check("wb_data_word2", 0, 32'(first_wb_data[0][47:32]), 32'h0000BEEF);
        check("wb_data_word0", 0, 32'(first_wb_data[0][15:0]), 32'h00000080);
        check("wb_data_word0", 1, 32'(first_wb_data[1][15:0]), 32'h00001111);

        // Eight back-to-back write hits with the strobe held high.
        pulses = 0;
        mem_write[0] = 1'b1; mem_byte_enable[0] = 2'b11;
        for (int k = 0; k < 8; k++) begin
            mem_address[0] = 16'h1230 + 16'(2 * k);
            mem_wdata[0]   = 16'hC000 + 16'(k);
            @(negedge clk);
            if (mem_resp[0]) pulses++;
            @(posedge clk); #1;
        end
        mem_write[0] = 1'b0;
        $display("burst write u0 line 1230: %0d responses", pulses);
        check("burst_pulses", 0, 32'(pulses), 32'd8);
        for (int k = 0; k < 8; k++) begin
            access(0, 1'b1, 1'b0, 16'h1230 + 16'(2 * k), 16'h0000, 2'b00, lat, rdata);
            $display("readback u0 addr=%h lat=%0d rdata=%h", 16'h1230 + 16'(2 * k), lat, rdata);
            check("burst_lat", k, 32'(lat), 32'd0);
            check("burst_rdata", k, 32'(rdata), 32'hC000 + 32'(k));
        end

        // Reset in the middle of a fill, then a stray pmem_resp.
        hold[0] = 1'b1;
        mem_read[0] = 1'b1; mem_address[0] = 16'h3000;
        saw_fill = 1'b0;
        for (int c = 0; c < 10 && !saw_fill; c++) begin
            @(negedge clk);
            saw_fill = pmem_read[0];
        end
        check("fill_started", 0, 32'(saw_fill), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        $display("reset asserted mid-fill: pmem_read=%0d pmem_write=%0d", pmem_read[0], pmem_write[0]);
        check("rst_fill_read", 0, 32'(pmem_read[0]), 32'd0);
        check("rst_fill_write", 0, 32'(pmem_write[0]), 32'd0);
        check("rst_fill_resp", 0, 32'(mem_resp[0]), 32'd0);
        mem_read[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        inject[0] = 1'b1;
        @(negedge clk);
        inject[0] = 1'b0;
        check("stray_resp_read", 0, 32'(pmem_read[0]), 32'd0);
        @(negedge clk);
        check("after_stray_read", 0, 32'(pmem_read[0]), 32'd0);
        check("after_stray_write", 0, 32'(pmem_write[0]), 32'd0);
        check("after_stray_resp", 0, 32'(mem_resp[0]), 32'd0);
        hold[0] = 1'b0;
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, lat, rdata);
        $display("post-reset u0 addr=1234 lat=%0d rdata=%h", lat, rdata);
        check("post_reset_lat", 0, 32'(lat), 32'd3);
        check("post_reset_rdata", 0, 32'(rdata), 32'h00001232);
        check("post_reset_fill", 0, 32'(last_fill[0]), 32'h00001230);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
